nonce_result_arbiter: RTL

- Collects golden-nonce results from NUM_CORES hashing cores inside bcminer and serialises them onto the single nonce-buffer write port.
- Each core gets a one-entry holding slot. Occupied slots are served round-robin through a registered valid/ready output stage.
- A per-block flush discards stale results when a new block header is loaded.
- Overflowing results are dropped and counted.

---
 rtl/bc_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/nonce_result_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Shared bcminer types: nonce/core-id widths and the result record passed to the nonce buffer.
package bc_pkg;

  localparam int unsigned NUM_CORES_DEF = 10;
  localparam int unsigned NONCE_W_DEF   = 32;
  localparam int unsigned COUNTBITS_DEF = 4;
  localparam int unsigned ID_W_DEF      = $clog2(NUM_CORES_DEF);

  typedef logic [NONCE_W_DEF-1:0] nonce_t;
  typedef logic [ID_W_DEF-1:0]    core_id_t;

  typedef struct packed {
    nonce_t   nonce;
    core_id_t id;
  } nonce_result_t;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_val);
    return ((a + b) > max_val) ? max_val : (a + b);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over a request vector; the search starts at an internal pointer that
// moves one past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int unsigned NUM_CORES = 10,
  localparam int unsigned ID_W      = $clog2(NUM_CORES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_CORES-1:0] i_req,
  input  logic                 i_en,
  output logic [NUM_CORES-1:0] o_gnt,
  output logic [ID_W-1:0]      o_gnt_idx,
  output logic                 o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_c;
  int unsigned     w_sum;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_sum     = 0;
    w_c       = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      // r_ptr < NUM_CORES and k < NUM_CORES, so one subtraction wraps the candidate index
      w_sum = 32'(r_ptr) + k;
      w_c   = ID_W'((w_sum >= NUM_CORES) ? (w_sum - NUM_CORES) : w_sum);
      if (i_en && !o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt_idx  = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_gnt_idx == ID_W'(NUM_CORES - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_result_arbiter.sv
// Serialises golden nonces from NUM_CORES hashing cores onto the single nonce-buffer write
// port: one holding slot per core, round-robin service, flush on new block, drop counting.
module nonce_result_arbiter
  import bc_pkg::*;
#(
  parameter  int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter  int unsigned NONCE_W   = NONCE_W_DEF,
  parameter  int unsigned COUNTBITS = COUNTBITS_DEF,
  localparam int unsigned ID_W      = $clog2(NUM_CORES)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [NUM_CORES-1:0]         i_core_valid,
  input  logic [NUM_CORES*NONCE_W-1:0] i_core_nonce,
  output logic [NUM_CORES-1:0]         o_core_busy,
  output logic                         o_wr_valid,
  output logic [NONCE_W-1:0]           o_wr_nonce,
  output logic [ID_W-1:0]              o_wr_core,
  input  logic                         i_wr_ready,
  output logic [COUNTBITS-1:0]         o_drop_count
);

  localparam int unsigned DROP_MAX = (2 ** COUNTBITS) - 1;

  logic [NUM_CORES-1:0] r_slot_vld;
  logic [NONCE_W-1:0]   r_slot_nonce [NUM_CORES];
  logic                 r_wr_valid;
  logic [NONCE_W-1:0]   r_wr_nonce;
  logic [ID_W-1:0]      r_wr_core;
  logic [COUNTBITS-1:0] r_drop_cnt;

  logic                 w_load;
  logic                 w_gnt_en;
  logic                 w_any;
  logic [NUM_CORES-1:0] w_gnt;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [NUM_CORES-1:0] w_accept;
  logic [NUM_CORES-1:0] w_drop;
  int unsigned          w_drop_num;
  logic [COUNTBITS-1:0] w_drop_next;

  // The output register refills when empty or when its current word is being taken.
  assign w_load   = !r_wr_valid || i_wr_ready;
  assign w_gnt_en = w_load && !i_flush;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_arbiter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (r_slot_vld),
    .i_en      (w_gnt_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // A slot being drained this cycle can take a new nonce in the same cycle.
  assign w_accept    = i_core_valid & (~r_slot_vld | w_gnt);
  assign w_drop      = i_core_valid & r_slot_vld & ~w_gnt;
  assign o_core_busy = r_slot_vld & ~w_gnt;

  always_comb begin
    w_drop_num = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_drop_num = w_drop_num + 32'(w_drop[i]);
    end
  end

  assign w_drop_next = COUNTBITS'(sat_add(32'(r_drop_cnt), w_drop_num, DROP_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_vld <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        r_slot_nonce[i] <= '0;
      end
    end else if (i_flush) begin
      r_slot_vld <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (w_accept[i]) begin
          r_slot_vld[i]   <= 1'b1;
          r_slot_nonce[i] <= i_core_nonce[i*NONCE_W +: NONCE_W];
        end else if (w_gnt[i]) begin
          r_slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_valid <= 1'b0;
      r_wr_nonce <= '0;
      r_wr_core  <= '0;
    end else if (i_flush) begin
      r_wr_valid <= 1'b0;
    end else if (w_load) begin
      r_wr_valid <= w_any;
      if (w_any) begin
        r_wr_nonce <= r_slot_nonce[w_gnt_idx];
        r_wr_core  <= w_gnt_idx;
      end
    end
  end

  // Results arriving during a flush are stale, so they are neither captured nor counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (!i_flush) begin
      r_drop_cnt <= w_drop_next;
    end
  end

  assign o_wr_valid   = r_wr_valid;
  assign o_wr_nonce   = r_wr_nonce;
  assign o_wr_core    = r_wr_core;
  assign o_drop_count = r_drop_cnt;

endmodule
